// File: rtl/aibcr3aux_osc_freqmeas.sv
// AUX oscillator frequency checker: counts synchronized rising edges of the divide-by-16
// monitor clock over a programmable window of reference cycles, then grades against limits.
module aibcr3aux_osc_freqmeas #(
  parameter int WIN_W       = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkin,
  input  logic             irstb,
  input  logic             iosc_mon,
  input  logic             istart,
  input  logic             iabort,
  input  logic [WIN_W-1:0] iwin,
  input  logic [CNT_W-1:0] icnt_min,
  input  logic [CNT_W-1:0] icnt_max,
  output logic [CNT_W-1:0] ocnt,
  output logic             obusy,
  output logic             odone,
  output logic             opass,
  output logic             ofail_lo,
  output logic             ofail_hi
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   w_rise;
  logic [WIN_W-1:0]       r_win;
  logic [ARM_W-1:0]       r_arm_cnt;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic                   w_lo;
  logic                   w_hi;

  // Reset asserts asynchronously but releases on a clkin edge.
  always_ff @(posedge clkin or negedge irstb) begin
    if (!irstb) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clkin or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], iosc_mon};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_edge;

  // When min > max, a count below min reports low, anything else reports high.
  always_comb begin
    w_lo = 1'b0;
    w_hi = 1'b0;
    if (r_edge_cnt < icnt_min) begin
      w_lo = 1'b1;
    end else if (r_edge_cnt > icnt_max) begin
      w_hi = 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_arm_cnt  <= '0;
      r_edge_cnt <= '0;
      ocnt       <= '0;
      obusy      <= 1'b0;
      odone      <= 1'b0;
      opass      <= 1'b0;
      ofail_lo   <= 1'b0;
      ofail_hi   <= 1'b0;
    end else if (iabort) begin
      r_state  <= S_IDLE;
      obusy    <= 1'b0;
      odone    <= 1'b0;
      opass    <= 1'b0;
      ofail_lo <= 1'b0;
      ofail_hi <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (istart) begin
            r_state    <= S_ARM;
            r_win      <= iwin;
            r_arm_cnt  <= ARM_W'(SYNC_STAGES);
            r_edge_cnt <= '0;
            obusy      <= 1'b1;
            odone      <= 1'b0;
            opass      <= 1'b0;
            ofail_lo   <= 1'b0;
            ofail_hi   <= 1'b0;
          end
        end
        S_ARM: begin
          if (r_arm_cnt == '0) begin
            r_state <= (r_win == '0) ? S_CHECK : S_COUNT;
          end else begin
            r_arm_cnt <= r_arm_cnt - ARM_W'(1);
          end
        end
        S_COUNT: begin
          if (w_rise && (r_edge_cnt != '1)) begin
            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
          end
          r_win <= r_win - WIN_W'(1);
          if (r_win == WIN_W'(1)) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          ocnt     <= r_edge_cnt;
          ofail_lo <= w_lo;
          ofail_hi <= w_hi;
          opass    <= ~w_lo & ~w_hi;
          obusy    <= 1'b0;
          odone    <= 1'b1;
          r_state  <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          obusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
